// File: rtl/spi_minion_components_shift_engine_if.sv
// Word-level bus between the SPI minion front end and the shift engine.
// The front end drives serial/load/ack controls; the engine returns the live
// register, the serial output bit, the bit count and the captured word status.
interface spi_minion_components_shift_engine_if #(
   parameter int unsigned nbits = 8
);
   localparam int unsigned cbits = $clog2(nbits);

   logic             in_;
   logic             shift_en;
   logic             dir;
   logic             load_en;
   logic [nbits-1:0] load_data;
   logic [nbits-1:0] out;
   logic             serial_out;
   logic [cbits-1:0] bit_count;
   logic [nbits-1:0] word_data;
   logic             word_valid;
   logic             word_ack;
   logic             overrun;

   modport master (
      output in_, shift_en, dir, load_en, load_data, word_ack,
      input  out, serial_out, bit_count, word_data, word_valid, overrun
   );

   modport slave (
      input  in_, shift_en, dir, load_en, load_data, word_ack,
      output out, serial_out, bit_count, word_data, word_valid, overrun
   );
endinterface

// File: rtl/spi_minion_components_shift_engine.sv
// N-bit bidirectional shift engine with parallel load, shifted-bit counter and
// a captured-word buffer with valid/ack handshake and sticky overrun flag.
module spi_minion_components_shift_engine #(
   parameter int unsigned nbits       = 8,
   parameter logic        reset_value = 1'b0
)(
   input logic clk,
   input logic reset,
   spi_minion_components_shift_engine_if.slave bus
);
   localparam int unsigned cbits = $clog2(nbits);
   localparam logic [cbits-1:0] last_count = cbits'(nbits - 1);

   logic [nbits-1:0] shift_reg;
   logic [nbits-1:0] shifted;
   logic [cbits-1:0] count;
   logic [nbits-1:0] word_reg;
   logic             valid_reg;
   logic             overrun_reg;
   logic             do_shift;
   logic             complete;

   // Next register value for a shift in the currently selected direction.
   always_comb begin
      shifted  = shift_reg;
      do_shift = bus.shift_en & ~bus.load_en;
      complete = do_shift && (count == last_count);
      if (bus.dir) begin
         shifted = {bus.in_, shift_reg[nbits-1:1]};
      end else begin
         shifted = {shift_reg[nbits-2:0], bus.in_};
      end
   end

   // Live shift register and bit counter; load takes priority over shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= {nbits{reset_value}};
         count     <= '0;
      end else if (bus.load_en) begin
         shift_reg <= bus.load_data;
         count     <= '0;
      end else if (bus.shift_en) begin
         shift_reg <= shifted;
         count     <= complete ? '0 : count + cbits'(1);
      end
   end

   // Captured word buffer: a completion always wins over an ack, and only an
   // unacknowledged word being overwritten raises the sticky overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (complete) begin
         word_reg  <= shifted;
         valid_reg <= 1'b1;
         if (valid_reg && !bus.word_ack) begin
            overrun_reg <= 1'b1;
         end
      end else if (bus.word_ack) begin
         valid_reg <= 1'b0;
      end
   end

   assign bus.out        = shift_reg;
   assign bus.serial_out = bus.dir ? shift_reg[0] : shift_reg[nbits-1];
   assign bus.bit_count  = count;
   assign bus.word_data  = word_reg;
   assign bus.word_valid = valid_reg;
   assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_spi_minion_components_shift_engine.sv
// Self-checking bench for the shift engine: directed scenarios plus a
// randomized run compared against a word-level behavioural model.
module tb_spi_minion_components_shift_engine;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_minion_components_shift_engine_if #(.nbits(8)) bus ();
   spi_minion_components_shift_engine_if #(.nbits(8)) bus1 ();

   spi_minion_components_shift_engine #(.nbits(8), .reset_value(1'b0)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   spi_minion_components_shift_engine #(.nbits(8), .reset_value(1'b1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   // Behavioural model of the reset_value=0 instance.
   logic [7:0] m_out = 8'h00;
   int         m_cnt = 0;
   logic [7:0] m_wd  = 8'h00;
   logic       m_wv  = 1'b0;
   logic       m_ov  = 1'b0;

   // Apply one cycle of inputs, wait for the edge, advance the model, then
   // settle 1 time unit past the edge so outputs can be sampled.
   task automatic cycle(input logic r, input logic ld, input logic sh,
                        input logic d, input logic i, input logic ack,
                        input logic [7:0] ldata);
      logic done;
      reset         = r;
      bus.load_en   = ld;
      bus.shift_en  = sh;
      bus.dir       = d;
      bus.in_       = i;
      bus.word_ack  = ack;
      bus.load_data = ldata;
      @(posedge clk);
      done = 1'b0;
      if (r) begin
         m_out = 8'h00; m_cnt = 0; m_wd = 8'h00; m_wv = 1'b0; m_ov = 1'b0;
      end else begin
         if (ld) begin
            m_out = ldata;
            m_cnt = 0;
         end else if (sh) begin
            if (d) m_out = (m_out >> 1) | (8'(i) << 7);
            else   m_out = (m_out << 1) | 8'(i);
            m_cnt = m_cnt + 1;
            if (m_cnt == 8) begin
               m_cnt = 0;
               if (m_wv && !ack) m_ov = 1'b1;
               m_wd = m_out;
               m_wv = 1'b1;
               done = 1'b1;
            end
         end
         if (!done && ack) m_wv = 1'b0;
      end
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;
   endtask

   // Eight shifts of one byte in the chosen framing; optional ack on the last.
   task automatic send_word(input logic [7:0] data, input logic d, input logic ack_last);
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 1'b0, 1'b1, d, d ? data[k] : data[7-k],
               (k == 7) ? ack_last : 1'b0, 8'h00);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out0: got %h want 00", bus.out); end
      if (bus1.out !== 8'hFF) begin errors++; $display("FAIL reset_out1: got %h want ff", bus1.out); end
      if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.bit_count); end
      if (bus.word_data !== 8'h00) begin errors++; $display("FAIL reset_wd: got %h want 00", bus.word_data); end
      if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_wv: got %b want 0", bus.word_valid); end
      if (bus.overrun !== 1'b0 || bus1.overrun !== 1'b0 || bus1.word_valid !== 1'b0)
         begin errors++; $display("FAIL reset_ov: got %b/%b want 0", bus.overrun, bus1.overrun); end
   endtask

   task automatic test_msb_first();
      logic [7:0] data = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, data[7-k], 1'b0, 8'h00);
         if (k < 7) begin
            checks++;
            if (bus.word_valid !== 1'b0 || bus.bit_count !== 3'(k + 1)) begin
               errors++;
               $display("FAIL msb_progress: got wv=%b cnt=%0d want wv=0 cnt=%0d", bus.word_valid, bus.bit_count, k + 1);
            end
         end
      end
      checks += 4;
      if (bus.out !== 8'hA5) begin errors++; $display("FAIL msb_out: got %h want a5", bus.out); end
      if (bus.word_data !== 8'hA5) begin errors++; $display("FAIL msb_wd: got %h want a5", bus.word_data); end
      if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL msb_wv: got %b want 1", bus.word_valid); end
      if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL msb_cnt: got %0d want 0", bus.bit_count); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL msb_ack: got %b want 0", bus.word_valid); end
   endtask

   task automatic test_lsb_first();
      send_word(8'hA5, 1'b1, 1'b0);
      checks += 3;
      if (bus.word_data !== 8'hA5) begin errors++; $display("FAIL lsb_wd: got %h want a5", bus.word_data); end
      if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL lsb_wv: got %b want 1", bus.word_valid); end
      if (bus.out !== 8'hA5) begin errors++; $display("FAIL lsb_out: got %h want a5", bus.out); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_load_transmit();
      logic [7:0] exp_so = 8'b0011_1100;
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
      checks += 2;
      if (bus.out !== 8'h3C) begin errors++; $display("FAIL load_out: got %h want 3c", bus.out); end
      if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL load_cnt: got %0d want 0", bus.bit_count); end
      bus.dir = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (bus.serial_out !== exp_so[7-k]) begin
            errors++;
            $display("FAIL tx_serial_out[%0d]: got %b want %b", k, bus.serial_out, exp_so[7-k]);
         end
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      checks += 3;
      if (bus.word_data !== 8'h22) begin errors++; $display("FAIL ovr_wd: got %h want 22", bus.word_data); end
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
      if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL ovr_wv: got %b want 1", bus.word_valid); end
      idle();
      checks++;
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
      do_reset();
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b1);
      checks += 3;
      if (bus.word_data !== 8'h22) begin errors++; $display("FAIL simack_wd: got %h want 22", bus.word_data); end
      if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL simack_wv: got %b want 1", bus.word_valid); end
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simack_ov: got %b want 0", bus.overrun); end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] data = 8'hC3;
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks += 2;
      if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", bus.bit_count); end
      if (bus.word_valid !== 1'b0 || bus.word_data !== 8'h00)
         begin errors++; $display("FAIL mid_word: got wv=%b wd=%h want wv=0 wd=00", bus.word_valid, bus.word_data); end
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, data[7-k], 1'b0, 8'h00);
         checks++;
         if (k < 7) begin
            if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL mid_early_wv[%0d]: got %b want 0", k, bus.word_valid); end
         end else if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hC3) begin
            errors++;
            $display("FAIL mid_word_c3: got wv=%b wd=%h want wv=1 wd=c3", bus.word_valid, bus.word_data);
         end
      end
   endtask

   task automatic test_random();
      logic r, ld, sh, d, i, ack;
      logic [7:0] ldata;
      for (int n = 0; n < 600; n++) begin
         r     = ($urandom_range(0, 79) == 0);
         ld    = ($urandom_range(0, 15) == 0);
         sh    = ($urandom_range(0, 3) != 0);
         d     = ($urandom_range(0, 5) == 0) ? ~bus.dir : bus.dir;
         i     = 1'($urandom);
         ack   = ($urandom_range(0, 5) == 0);
         ldata = 8'($urandom);
         cycle(r, ld, sh, d, i, ack, ldata);
         checks += 6;
         if (bus.out !== m_out) begin errors++; $display("FAIL rnd_out@%0d: got %h want %h", n, bus.out, m_out); end
         if (bus.bit_count !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, bus.bit_count, m_cnt); end
         if (bus.word_data !== m_wd) begin errors++; $display("FAIL rnd_wd@%0d: got %h want %h", n, bus.word_data, m_wd); end
         if (bus.word_valid !== m_wv) begin errors++; $display("FAIL rnd_wv@%0d: got %b want %b", n, bus.word_valid, m_wv); end
         if (bus.overrun !== m_ov) begin errors++; $display("FAIL rnd_ov@%0d: got %b want %b", n, bus.overrun, m_ov); end
         if (bus.serial_out !== (d ? m_out[0] : m_out[7]))
            begin errors++; $display("FAIL rnd_so@%0d: got %b want %b", n, bus.serial_out, d ? m_out[0] : m_out[7]); end
      end
   endtask

   initial begin
      bus.in_ = 1'b0; bus.shift_en = 1'b0; bus.dir = 1'b0; bus.load_en = 1'b0;
      bus.load_data = 8'h00; bus.word_ack = 1'b0;
      bus1.in_ = 1'b0; bus1.shift_en = 1'b0; bus1.dir = 1'b0; bus1.load_en = 1'b0;
      bus1.load_data = 8'h00; bus1.word_ack = 1'b0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_load_transmit();
      test_overrun();
      test_reset_mid_word();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
